// File: rtl/ef_ahbl_master.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command becomes one
// NONSEQ SINGLE transfer, with the result returned on a valid/ready response.
module ef_ahbl_master #(
  parameter logic [3:0] HPROT_VAL  = 4'b0011,
  parameter int         WAIT_CNT_W = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [WAIT_CNT_W-1:0] rsp_waits,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_t;

  localparam logic [1:0]            TR_IDLE   = 2'b00;
  localparam logic [1:0]            TR_NONSEQ = 2'b10;
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

  state_t                state;
  logic [31:0]           wdata_q;
  logic [WAIT_CNT_W-1:0] wcnt;
  logic                  bad_cmd;

  assign cmd_ready = (state == IDLE);
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  // Oversized or misaligned requests are answered locally without touching the bus.
  always_comb begin
    bad_cmd = (cmd_size > 3'd2) ||
              ((cmd_size == 3'd1) && cmd_addr[0]) ||
              ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b010;
      HWDATA    <= '0;
      wdata_q   <= '0;
      wcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_waits <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (bad_cmd) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            rsp_waits <= '0;
            state     <= RSP;
          end else begin
            HADDR   <= cmd_addr;
            HWRITE  <= cmd_write;
            HSIZE   <= cmd_size;
            HTRANS  <= TR_NONSEQ;
            wdata_q <= cmd_wdata;
            state   <= ADDR;
          end
        end
        ADDR: if (HREADY) begin
          HTRANS <= TR_IDLE;
          if (HWRITE) HWDATA <= wdata_q;
          wcnt  <= '0;
          state <= DATA;
        end
        // The first ERROR cycle arrives with HREADY low and is counted as a wait.
        DATA: if (!HREADY) begin
          if (wcnt != '1) wcnt <= wcnt + CNT_ONE;
        end else begin
          rsp_err   <= HRESP;
          rsp_rdata <= (!HWRITE && !HRESP) ? HRDATA : '0;
          rsp_waits <= wcnt;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ef_ahbl_master.sv
// Bench for ef_ahbl_master: behavioural AHB slave, reference memory model and
// a response scoreboard checked by an independent monitor.
module tb_ef_ahbl_master;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_waits;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 HCLK = ~HCLK;

  ef_ahbl_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_waits(rsp_waits),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: words 0x00..0x18 mapped, 0x40 answers ERROR, the rest reads DEADBEEF.
  int          slv_waits = 0;
  logic        dp_active, dp_write;
  logic [31:0] dp_addr;
  int          dp_cnt;
  logic [31:0] mem [8] = '{default: 32'h0};
  logic        dp_err;

  assign dp_err = dp_active && (dp_addr == 32'h40);
  assign HRESP  = dp_err;
  assign HREADY = !dp_active || (dp_err ? (dp_cnt >= 1) : (dp_cnt >= slv_waits));
  assign HRDATA = (dp_active && !dp_write) ?
                  ((dp_addr < 32'h1C) ? mem[dp_addr[4:2]] : 32'hDEADBEEF) : 32'h0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_addr   <= 32'h0;
      dp_cnt    <= 0;
    end else if (dp_active && HREADY) begin
      if (dp_write && !dp_err && dp_addr < 32'h1C) mem[dp_addr[4:2]] <= HWDATA;
      dp_active <= 1'b0;
    end else if (dp_active) begin
      dp_cnt <= dp_cnt + 1;
    end else if (HTRANS == 2'b10) begin
      dp_active <= 1'b1;
      dp_write  <= HWRITE;
      dp_addr   <= HADDR;
      dp_cnt    <= 0;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  waits;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_mem [8];

  task automatic push_exp(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] d);
    exp_t e;
    logic bad;
    bad = (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
    if (bad) e = '{1'b1, 32'h0, 8'h0};
    else if (a == 32'h40) e = '{1'b1, 32'h0, 8'h1};
    else if (w) begin
      if (a < 32'h1C) model_mem[a[4:2]] = d;
      e = '{1'b0, 32'h0, 8'(slv_waits)};
    end else
      e = '{1'b0, (a < 32'h1C) ? model_mem[a[4:2]] : 32'hDEADBEEF, 8'(slv_waits)};
    exp_q.push_back(e);
  endtask

  // Monitor: one pop per response handshake.
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'h1, 32'h0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_waits", {24'h0, rsp_waits}, {24'h0, e.waits});
      end
    end
  end

  // Offer a command; returns #1 after the accepting edge (cycle T+1).
  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin @(posedge HCLK); #1; n++; end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'h0, 32'h1);
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge HCLK); #1; n++; end
    chk("rsp_drain", exp_q.size(), 32'h0);
  endtask

  task automatic tick(input int k);
    repeat (k) begin @(posedge HCLK); #1; end
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = 3'd2; cmd_wdata = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
    #12;
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("rst_hsize", {29'h0, HSIZE}, 32'h2);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_waits", {24'h0, rsp_waits}, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("const_hprot", {28'h0, HPROT}, 32'h3);
    chk("const_hburst", {29'h0, HBURST}, 32'h0);
    tick(2);
    HRESETn = 1'b1;
    tick(1);

    // Preload 0x3E8 at 0x8.
    push_exp(1'b1, 32'h8, 3'd2, 32'h3E8);
    send(1'b1, 32'h8, 3'd2, 32'h3E8);
    wait_done();

    // Zero-wait write, cycle by cycle.
    push_exp(1'b1, 32'h10, 3'd2, 32'h7);
    send(1'b1, 32'h10, 3'd2, 32'h7);
    chk("w_nonseq", {30'h0, HTRANS}, 32'h2);
    chk("w_haddr", HADDR, 32'h10);
    chk("w_hwrite", {31'h0, HWRITE}, 32'h1);
    tick(1);
    chk("w_hwdata", HWDATA, 32'h7);
    chk("w_htrans_idle", {30'h0, HTRANS}, 32'h0);
    tick(1);
    chk("w_rsp_t3", {31'h0, rsp_valid}, 32'h1);
    wait_done();

    // Three wait states, mapped then unmapped.
    slv_waits = 3;
    for (int r = 0; r < 2; r++) begin
      logic [31:0] a;
      a = (r == 0) ? 32'h8 : 32'h1C;
      push_exp(1'b0, a, 3'd2, 32'h0);
      send(1'b0, a, 3'd2, 32'h0);
      chk("r_nonseq", {30'h0, HTRANS}, 32'h2);
      for (int k = 0; k < 4; k++) begin
        tick(1);
        chk("r_wait_htrans", {30'h0, HTRANS}, 32'h0);
        chk("r_wait_rsp", {31'h0, rsp_valid}, 32'h0);
      end
      tick(1);
      chk("r_rsp_t6", {31'h0, rsp_valid}, 32'h1);
      wait_done();
    end
    slv_waits = 0;

    // Two-cycle ERROR response.
    push_exp(1'b0, 32'h40, 3'd2, 32'h0);
    send(1'b0, 32'h40, 3'd2, 32'h0);
    tick(1);
    chk("e_htrans1", {30'h0, HTRANS}, 32'h0);
    tick(1);
    chk("e_htrans2", {30'h0, HTRANS}, 32'h0);
    chk("e_rsp_early", {31'h0, rsp_valid}, 32'h0);
    tick(1);
    chk("e_rsp_t4", {31'h0, rsp_valid}, 32'h1);
    wait_done();

    // Local errors: misaligned word, size 3.
    push_exp(1'b1, 32'h2, 3'd2, 32'h1);
    send(1'b1, 32'h2, 3'd2, 32'h1);
    chk("bad_align_htrans", {30'h0, HTRANS}, 32'h0);
    chk("bad_align_rsp_t1", {31'h0, rsp_valid}, 32'h1);
    wait_done();
    push_exp(1'b1, 32'h0, 3'd3, 32'h1);
    send(1'b1, 32'h0, 3'd3, 32'h1);
    chk("bad_size_htrans", {30'h0, HTRANS}, 32'h0);
    chk("bad_size_rsp_t1", {31'h0, rsp_valid}, 32'h1);
    wait_done();

    // Response back-pressure with a pending command.
    rsp_ready = 1'b0;
    push_exp(1'b0, 32'h8, 3'd2, 32'h0);
    send(1'b0, 32'h8, 3'd2, 32'h0);
    push_exp(1'b1, 32'h14, 3'd2, 32'h55);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h14; cmd_size = 3'd2; cmd_wdata = 32'h55;
    tick(2);
    for (int k = 0; k < 5; k++) begin
      chk("hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h3E8);
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(1);
    chk("hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("hs_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("hs_htrans", {30'h0, HTRANS}, 32'h0);
    tick(1);
    chk("next_nonseq", {30'h0, HTRANS}, 32'h2);
    chk("next_haddr", HADDR, 32'h14);
    cmd_valid = 1'b0;
    wait_done();

    // Back-to-back random traffic against the zero-wait slave.
    for (int i = 0; i < 300; i++) begin
      logic        w;
      logic [31:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 6)) << 2;
      d = $urandom;
      push_exp(w, a, 3'd2, d);
      send(w, a, 3'd2, d);
    end
    wait_done();

    // Reset during a stalled write data phase.
    slv_waits = 5;
    send(1'b1, 32'h18, 3'd2, 32'hA5A5);
    tick(1);
    chk("rst_pre_hwdata", HWDATA, 32'hA5A5);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("arst_haddr", HADDR, 32'h0);
    tick(2);
    HRESETn = 1'b1;
    slv_waits = 0;
    tick(1);
    chk("arst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    push_exp(1'b0, 32'h18, 3'd2, 32'h0);
    send(1'b0, 32'h18, 3'd2, 32'h0);
    wait_done();

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
